// File: rtl/mem_access_arbiter.sv
// Memory-access controller: routes one read request to a bank ROM,
// issues pipelined word reads and packs them into one wide response.
module mem_access_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int MEM_W     = 16,
    parameter int BEATS_MAX = 3,
    parameter int MEM_LAT   = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LEN_W    = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1,
    localparam int DATA_W   = BEATS_MAX * MEM_W
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [CH_W-1:0]         REQ_CH,
    input  logic [ADDR_W-1:0]       REQ_ADDR,
    input  logic [LEN_W-1:0]        REQ_LEN,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_W-1:0]       RSP_DATA,
    output logic                    RSP_ERR,
    output logic [NUM_CH-1:0]       MEM_EN,
    output logic [ADDR_W-1:0]       MEM_ADDR,
    input  logic [NUM_CH*MEM_W-1:0] MEM_RDATA
);

    localparam logic [LEN_W-1:0] LAST_MAX = LEN_W'(BEATS_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic              rdy_q;
    logic [CH_W-1:0]   ch_q;
    logic [LEN_W-1:0]  last_q;
    logic [LEN_W-1:0]  beat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NUM_CH-1:0] en_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;

    logic [MEM_LAT-1:0] pv;
    logic [LEN_W-1:0]   pi [MEM_LAT];

    logic              accept;
    logic              ch_ok;
    logic              cap;
    logic              cap_last;
    logic [LEN_W-1:0]  req_last;
    logic [MEM_W-1:0]  bank_rd [NUM_CH];
    logic [MEM_W-1:0]  rd_word;

    assign ch_ok    = (32'(REQ_CH) < NUM_CH);
    assign req_last = (REQ_LEN > LAST_MAX) ? LAST_MAX : REQ_LEN;
    assign accept   = REQ_VALID && REQ_READY;
    assign cap      = pv[MEM_LAT-1];
    assign cap_last = cap && (pi[MEM_LAT-1] == last_q);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            bank_rd[k] = MEM_RDATA[k*MEM_W +: MEM_W];
        end
    end

    assign rd_word = bank_rd[ch_q];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = ch_ok ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                if (beat_q == last_q) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cap_last) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = rdy_q && (state == S_IDLE);
        RSP_VALID = (state == S_RESP);
        RSP_ERR   = err_q && (state == S_RESP);
        RSP_DATA  = data_q;
        MEM_EN    = en_q;
        MEM_ADDR  = addr_q;
    end

    // The valid/beat shift pipe tracks reads in flight so issue never waits on latency
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdy_q  <= 1'b0;
            ch_q   <= '0;
            last_q <= '0;
            beat_q <= '0;
            addr_q <= '0;
            en_q   <= '0;
            err_q  <= 1'b0;
            data_q <= '0;
            pv     <= '0;
            for (int j = 0; j < MEM_LAT; j++) begin
                pi[j] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            pv[0] <= |en_q;
            pi[0] <= beat_q;
            for (int j = 1; j < MEM_LAT; j++) begin
                pv[j] <= pv[j-1];
                pi[j] <= pi[j-1];
            end
            if (cap) begin
                data_q[32'(pi[MEM_LAT-1])*MEM_W +: MEM_W] <= rd_word;
            end
            if (accept) begin
                ch_q   <= REQ_CH;
                addr_q <= REQ_ADDR;
                last_q <= req_last;
                beat_q <= '0;
                err_q  <= !ch_ok;
                data_q <= '0;
                en_q   <= ch_ok ? (NUM_CH'(1) << REQ_CH) : '0;
            end else if (state == S_ISSUE) begin
                if (beat_q == last_q) begin
                    en_q <= '0;
                end else begin
                    beat_q <= beat_q + LEN_W'(1);
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: scoreboarded main instance plus a
// 3-bank, 3-cycle-latency instance for error and latency cases.
module tb_mem_access_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_CH;
    logic [31:0] REQ_ADDR;
    logic [1:0]  REQ_LEN;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [47:0] RSP_DATA;
    logic        RSP_ERR;
    logic [1:0]  MEM_EN;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_RDATA;

    logic        B_REQ_VALID;
    logic        B_REQ_READY;
    logic [1:0]  B_REQ_CH;
    logic [31:0] B_REQ_ADDR;
    logic [1:0]  B_REQ_LEN;
    logic        B_RSP_VALID;
    logic        B_RSP_READY;
    logic [47:0] B_RSP_DATA;
    logic        B_RSP_ERR;
    logic [2:0]  B_MEM_EN;
    logic [31:0] B_MEM_ADDR;
    logic [47:0] B_MEM_RDATA;

    mem_access_arbiter #(
        .NUM_CH(2), .ADDR_W(32), .MEM_W(16), .BEATS_MAX(3), .MEM_LAT(1)
    ) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CH(REQ_CH), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA)
    );

    mem_access_arbiter #(
        .NUM_CH(3), .ADDR_W(32), .MEM_W(16), .BEATS_MAX(3), .MEM_LAT(3)
    ) u_dut_b (
        .CLK(CLK), .RESET_N(RESET_N),
        .REQ_VALID(B_REQ_VALID), .REQ_READY(B_REQ_READY),
        .REQ_CH(B_REQ_CH), .REQ_ADDR(B_REQ_ADDR), .REQ_LEN(B_REQ_LEN),
        .RSP_VALID(B_RSP_VALID), .RSP_READY(B_RSP_READY),
        .RSP_DATA(B_RSP_DATA), .RSP_ERR(B_RSP_ERR),
        .MEM_EN(B_MEM_EN), .MEM_ADDR(B_MEM_ADDR), .MEM_RDATA(B_MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] romval(input int b, input logic [31:0] a);
        if (b == 0 && a == 32'h10) return 16'hBEEF;
        if (b == 1 && a == 32'h20) return 16'h1111;
        if (b == 1 && a == 32'h21) return 16'h2222;
        if (b == 1 && a == 32'h22) return 16'h3333;
        if (b == 0) return a[15:0] ^ 16'h5A5A;
        if (b == 1) return a[15:0] ^ 16'hA5A5;
        return a[15:0] ^ 16'h3C3C;
    endfunction

    // Bank ROMs: latency 1 for the main instance, 3 for the second
    logic [15:0] rd0, rd1;
    always @(posedge CLK) begin
        if (MEM_EN[0]) rd0 <= romval(0, MEM_ADDR);
        if (MEM_EN[1]) rd1 <= romval(1, MEM_ADDR);
    end
    assign MEM_RDATA = {rd1, rd0};

    logic [15:0] bp [3][3];
    always @(posedge CLK) begin
        for (int b = 0; b < 3; b++) begin
            if (B_MEM_EN[b]) bp[b][0] <= romval(b, B_MEM_ADDR);
            bp[b][1] <= bp[b][0];
            bp[b][2] <= bp[b][1];
        end
    end
    assign B_MEM_RDATA = {bp[2][2], bp[1][2], bp[0][2]};

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [31:0] addr;
        int          rel;
        int          acc;
    } iss_t;

    typedef struct {
        logic [47:0] data;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    always @(negedge CLK) begin
        iss_t e;
        if (MEM_EN != 2'b00) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_mem_en", 64'(MEM_EN), 64'h0);
            end else begin
                e = iss_q.pop_front();
                chk("mem_en", 64'(MEM_EN), 64'(e.en));
                chk("mem_addr", 64'(MEM_ADDR), 64'(e.addr));
                chk("mem_en_cycle", 64'(cyc - e.acc), 64'(e.rel));
            end
        end
    end

    int   vstart = 0;
    logic prev_v = 1'b0;
    always @(negedge CLK) begin
        rsp_t r;
        if (RSP_VALID && !prev_v) vstart = cyc;
        prev_v = RSP_VALID;
        if (RSP_VALID && RSP_READY) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(RSP_VALID), 64'h0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_data", 64'(RSP_DATA), 64'(r.data));
                chk("rsp_err", 64'(RSP_ERR), 64'(r.err));
                chk("rsp_cycle", 64'(vstart - r.acc), 64'(r.lat));
            end
        end
    end

    task automatic send(input logic ch, input logic [31:0] addr,
                        input logic [1:0] len, input logic [47:0] ed,
                        input logic ee, input int lat, input int nb);
        int   t;
        iss_t e;
        rsp_t r;
        @(posedge CLK); #1;
        REQ_VALID = 1'b1;
        REQ_CH    = ch;
        REQ_ADDR  = addr;
        REQ_LEN   = len;
        t = 0;
        while (!REQ_READY && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("req_ready", 64'(REQ_READY), 64'h1);
        for (int k = 0; k < nb; k++) begin
            e.en   = 2'(1) << ch;
            e.addr = addr + 32'(k);
            e.rel  = k + 1;
            e.acc  = cyc;
            iss_q.push_back(e);
        end
        r.data = ed;
        r.err  = ee;
        r.lat  = lat;
        r.acc  = cyc;
        rsp_q.push_back(r);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        REQ_CH    = ~ch;
        REQ_ADDR  = 32'hDEAD_0000;
        REQ_LEN   = 2'd0;
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (!RSP_VALID && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("rsp_seen", 64'(RSP_VALID), 64'h1);
    endtask

    task automatic drain();
        int t = 0;
        while (rsp_q.size() != 0 && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("sb_drained", 64'(rsp_q.size()), 64'h0);
    endtask

    task automatic run_b(input string nm, input logic [1:0] ch,
                         input logic [31:0] addr, input logic [1:0] len,
                         input logic [47:0] ed, input logic ee,
                         input int lat, input int nb);
        int t;
        int acc;
        int en_cnt;
        int vcyc;
        logic [47:0] gd;
        logic        ge;
        @(posedge CLK); #1;
        B_REQ_VALID = 1'b1;
        B_REQ_CH    = ch;
        B_REQ_ADDR  = addr;
        B_REQ_LEN   = len;
        t = 0;
        while (!B_REQ_READY && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        chk({nm, "_ready"}, 64'(B_REQ_READY), 64'h1);
        acc = cyc;
        @(posedge CLK); #1;
        B_REQ_VALID = 1'b0;
        en_cnt = 0;
        vcyc   = -1;
        gd     = '0;
        ge     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (B_MEM_EN != 3'b000) en_cnt++;
            if (B_RSP_VALID && vcyc < 0) begin
                vcyc = cyc - acc;
                gd   = B_RSP_DATA;
                ge   = B_RSP_ERR;
            end
        end
        chk({nm, "_cycle"}, 64'(vcyc), 64'(lat));
        chk({nm, "_data"}, 64'(gd), 64'(ed));
        chk({nm, "_err"}, 64'(ge), 64'(ee));
        chk({nm, "_beats"}, 64'(en_cnt), 64'(nb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        RESET_N     = 1'b0;
        REQ_VALID   = 1'b0;
        REQ_CH      = 1'b0;
        REQ_ADDR    = '0;
        REQ_LEN     = '0;
        RSP_READY   = 1'b1;
        B_REQ_VALID = 1'b0;
        B_REQ_CH    = '0;
        B_REQ_ADDR  = '0;
        B_REQ_LEN   = '0;
        B_RSP_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", 64'(REQ_READY), 64'h0);
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'h0);
        chk("rst_rsp_err", 64'(RSP_ERR), 64'h0);
        chk("rst_rsp_data", 64'(RSP_DATA), 64'h0);
        chk("rst_mem_en", 64'(MEM_EN), 64'h0);
        chk("rst_mem_addr", 64'(MEM_ADDR), 64'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("rel_ready_before_edge", 64'(REQ_READY), 64'h0);
        @(posedge CLK); #1;
        chk("rel_ready_after_edge", 64'(REQ_READY), 64'h1);

        // T1: single beat, then one-cycle response and ready again
        send(1'b0, 32'h10, 2'd0, 48'h0000_0000_BEEF, 1'b0, 3, 1);
        wait_rsp();
        @(posedge CLK); #1;
        chk("t1_valid_drop", 64'(RSP_VALID), 64'h0);
        chk("t1_ready_back", 64'(REQ_READY), 64'h1);

        // T2: three beats on bank 1
        send(1'b1, 32'h20, 2'd2, 48'h3333_2222_1111, 1'b0, 5, 3);
        // T4: address wrap, then REQ_LEN clamped to BEATS_MAX
        send(1'b0, 32'hFFFF_FFFF, 2'd1, 48'h0000_5A5A_A5A5, 1'b0, 4, 2);
        send(1'b1, 32'h100, 2'd3, 48'hA4A7_A4A4_A4A5, 1'b0, 5, 3);
        drain();

        // T5: back-pressure holds the response, busy requests ignored
        RSP_READY = 1'b0;
        send(1'b0, 32'h30, 2'd0, 48'h0000_0000_5A6A, 1'b0, 3, 1);
        wait_rsp();
        REQ_VALID = 1'b1;
        REQ_CH    = 1'b1;
        REQ_ADDR  = 32'h77;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("t5_hold_valid", 64'(RSP_VALID), 64'h1);
            chk("t5_hold_data", 64'(RSP_DATA), 64'h0000_0000_5A6A);
            chk("t5_busy_ready", 64'(REQ_READY), 64'h0);
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        chk("t5_ready_back", 64'(REQ_READY), 64'h1);
        chk("t5_valid_drop", 64'(RSP_VALID), 64'h0);
        drain();

        // T6: reset during beat 1 discards the request
        send(1'b0, 32'h40, 2'd2, 48'h0, 1'b0, 5, 3);
        @(posedge CLK); #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_mem_en", 64'(MEM_EN), 64'h0);
        chk("t6_mem_addr", 64'(MEM_ADDR), 64'h0);
        chk("t6_req_ready", 64'(REQ_READY), 64'h0);
        chk("t6_rsp_data", 64'(RSP_DATA), 64'h0);
        iss_q.delete();
        rsp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        #1;
        chk("t6_ready_before_edge", 64'(REQ_READY), 64'h0);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (RSP_VALID) nv++;
        end
        chk("t6_no_rsp", 64'(nv), 64'h0);
        send(1'b1, 32'h21, 2'd0, 48'h0000_0000_2222, 1'b0, 3, 1);
        drain();

        // Second instance: latency 3 and nonexistent bank
        run_b("t2_lat3", 2'd1, 32'h20, 2'd2, 48'h3333_2222_1111, 1'b0, 7, 3);
        run_b("t3_err", 2'd3, 32'h20, 2'd2, 48'h0, 1'b1, 1, 0);
        run_b("b_bank2", 2'd2, 32'h5, 2'd0, 48'h0000_0000_3C39, 1'b0, 5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
